// File: rtl/adder_pipe.sv
// Pipelined adder/subtractor built from registered SW-bit carry-chain slices.
// One operand pair per cycle in, results STAGES cycles later, strictly in order.
module adder_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Per-stage registers: a_q/b_q carry the still-unprocessed upper operand
    // slices forward (skew), s_q carries the completed lower sum slices (de-skew).
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             v_q   [STAGES];
    logic             sub_q [STAGES];
    logic             cout_q;
    logic             ovf_q;

    logic [WIDTH-1:0] src_a   [STAGES];
    logic [WIDTH-1:0] src_b   [STAGES];
    logic [WIDTH-1:0] src_s   [STAGES];
    logic             src_c   [STAGES];
    logic             src_v   [STAGES];
    logic             src_sub [STAGES];
    logic [WIDTH-1:0] nxt_s   [STAGES];
    logic [SW:0]      slice   [STAGES];

    logic adv;
    logic msb_cin;
    logic cout_n;
    logic ovf_n;

    assign adv      = !v_q[LAST] || out_ready;
    assign in_ready = adv;

    // Stage 0 takes conditioned operands (subtract is a + ~b + ~cin); later
    // stages take their predecessor's registers.
    always_comb begin
        src_a[0]   = a;
        src_b[0]   = sub ? ~b : b;
        src_s[0]   = '0;
        src_c[0]   = sub ? ~cin : cin;
        src_v[0]   = in_valid;
        src_sub[0] = sub;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_s[k]   = s_q[k-1];
            src_c[k]   = c_q[k-1];
            src_v[k]   = v_q[k-1];
            src_sub[k] = sub_q[k-1];
        end
    end

    // Each stage adds only its own slice, so the carry chain is SW bits long.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            slice[k] = {1'b0, src_a[k][k*SW +: SW]}
                     + {1'b0, src_b[k][k*SW +: SW]}
                     + {{SW{1'b0}}, src_c[k]};
            nxt_s[k] = src_s[k];
            nxt_s[k][k*SW +: SW] = slice[k][SW-1:0];
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit of the last slice.
    always_comb begin
        msb_cin = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ slice[LAST][SW-1];
        cout_n  = slice[LAST][SW] ^ src_sub[LAST];
        ovf_n   = msb_cin ^ slice[LAST][SW];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                v_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
            end
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= src_a[k];
                b_q[k]   <= src_b[k];
                s_q[k]   <= nxt_s[k];
                c_q[k]   <= slice[k][SW];
                v_q[k]   <= src_v[k];
                sub_q[k] <= src_sub[k];
            end
            cout_q <= cout_n;
            ovf_q  <= ovf_n;
        end
    end

    // Result fields read zero whenever no result is presented.
    assign out_valid = v_q[LAST];
    assign sum       = out_valid ? s_q[LAST] : '0;
    assign cout      = out_valid & cout_q;
    assign ovf       = out_valid & ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: STAGES=4 main instance, plus STAGES=1 and
// STAGES=16 instances sharing the inputs for the streaming scenario.
module tb_adder_pipe;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          out_ready;
    logic          cin;
    logic          sub;
    logic [W-1:0]  a;
    logic [W-1:0]  b;

    logic          in_ready_d  [3];
    logic          out_valid_d [3];
    logic [W-1:0]  sum_d       [3];
    logic          cout_d      [3];
    logic          ovf_d       [3];

    int lat [3] = '{4, 1, 16};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(W), .STAGES(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_d[0]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_d[0]),
        .out_ready(out_ready), .sum(sum_d[0]), .cout(cout_d[0]), .ovf(ovf_d[0])
    );

    adder_pipe #(.WIDTH(W), .STAGES(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_d[1]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_d[1]),
        .out_ready(out_ready), .sum(sum_d[1]), .cout(cout_d[1]), .ovf(ovf_d[1])
    );

    adder_pipe #(.WIDTH(W), .STAGES(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_d[2]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_d[2]),
        .out_ready(out_ready), .sum(sum_d[2]), .cout(cout_d[2]), .ovf(ovf_d[2])
    );

    // Reference: plain wide arithmetic, overflow from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic s);
        logic [W:0]   full;
        logic [W-1:0] r;
        logic         v;
        if (!s) begin
            full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            r    = full[W-1:0];
            v    = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        end else begin
            full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, ci};
            r    = full[W-1:0];
            v    = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        end
        return {r, full[W], v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic s);
        a        = x;
        b        = y;
        cin      = ci;
        sub      = s;
        in_valid = 1'b1;
    endtask

    task automatic flush(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2;
        n_checks++;
        if (out_valid_d[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid_d[0]); end
        n_checks++;
        if (sum_d[0] !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_sum: got %h expected 0000", sum_d[0]); end
        n_checks++;
        if ({cout_d[0], ovf_d[0]} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 00", {cout_d[0], ovf_d[0]}); end
        n_checks++;
        if (in_ready_d[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready_d[0]); end
        tick(); tick();
        #3 reset = 1'b0;
        tick();
        n_checks++;
        if (in_ready_d[0] !== 1'b1 || out_valid_d[0] !== 1'b0) begin
            n_fail++; $display("[TB] FAIL post_reset: got in_ready=%b out_valid=%b expected 1/0", in_ready_d[0], out_valid_d[0]);
        end
    endtask

    task automatic test_add_wrap();
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick(); tick(); #1;
        n_checks++;
        if (out_valid_d[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL add_wrap_early: got out_valid=%b expected 0", out_valid_d[0]); end
        tick(); #1;
        n_checks++;
        if (out_valid_d[0] !== 1'b1 || sum_d[0] !== 16'h0000 || cout_d[0] !== 1'b1 || ovf_d[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL add_wrap: got v=%b sum=%h c=%b o=%b expected 1/0000/1/0", out_valid_d[0], sum_d[0], cout_d[0], ovf_d[0]);
        end
        tick(); #1;
        n_checks++;
        if (out_valid_d[0] !== 1'b0 || sum_d[0] !== 16'h0000 || cout_d[0] !== 1'b0) begin
            n_fail++; $display("[TB] FAIL add_wrap_idle_zero: got v=%b sum=%h c=%b expected 0/0000/0", out_valid_d[0], sum_d[0], cout_d[0]);
        end
    endtask

    task automatic test_sub_overflow();
        logic [W-1:0] va   [2] = '{16'h8000, 16'h0003};
        logic [W-1:0] vb   [2] = '{16'h0001, 16'h0005};
        logic         vc   [2] = '{1'b0, 1'b1};
        logic [W-1:0] es   [2] = '{16'h7FFF, 16'hFFFD};
        logic         ec   [2] = '{1'b0, 1'b1};
        logic         eo   [2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            drive(va[i], vb[i], vc[i], 1'b1);
            tick();
            in_valid = 1'b0;
            tick(); tick(); tick(); #1;
            n_checks++;
            if (out_valid_d[0] !== 1'b1 || sum_d[0] !== es[i] || cout_d[0] !== ec[i] || ovf_d[0] !== eo[i]) begin
                n_fail++;
                $display("[TB] FAIL sub_overflow[%0d]: got v=%b sum=%h c=%b o=%b expected 1/%h/%b/%b",
                         i, out_valid_d[0], sum_d[0], cout_d[0], ovf_d[0], es[i], ec[i], eo[i]);
            end
            tick();
        end
    endtask

    task automatic test_slice_carry();
        logic [W-1:0] va   [2] = '{16'h0FFF, 16'h7FFF};
        logic [W-1:0] vb   [2] = '{16'h0001, 16'h0000};
        logic         vc   [2] = '{1'b0, 1'b1};
        logic [W-1:0] es   [2] = '{16'h1000, 16'h8000};
        logic         eo   [2] = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            drive(va[i], vb[i], vc[i], 1'b0);
            tick();
            in_valid = 1'b0;
            tick(); tick(); tick(); #1;
            n_checks++;
            if (out_valid_d[0] !== 1'b1 || sum_d[0] !== es[i] || cout_d[0] !== 1'b0 || ovf_d[0] !== eo[i]) begin
                n_fail++;
                $display("[TB] FAIL slice_carry[%0d]: got v=%b sum=%h c=%b o=%b expected 1/%h/0/%b",
                         i, out_valid_d[0], sum_d[0], cout_d[0], ovf_d[0], es[i], eo[i]);
            end
            tick();
        end
    endtask

    // 8 back-to-back pairs; each instance must present them on 8 consecutive
    // cycles starting STAGES-1 edges after the first acceptance.
    task automatic test_back_to_back();
        logic [W-1:0] ta [8];
        logic [W-1:0] tb [8];
        logic         tc [8];
        logic         ts [8];
        logic [W+1:0] ex [8];
        int           idx;
        flush(20);
        for (int i = 0; i < 8; i++) begin
            ta[i] = W'($urandom);
            tb[i] = W'($urandom);
            tc[i] = 1'($urandom);
            ts[i] = 1'($urandom);
            ex[i] = model(ta[i], tb[i], tc[i], ts[i]);
        end
        drive(ta[0], tb[0], tc[0], ts[0]);
        for (int e = 0; e < 25; e++) begin
            tick();
            if (e + 1 < 8) drive(ta[e+1], tb[e+1], tc[e+1], ts[e+1]);
            else in_valid = 1'b0;
            #1;
            for (int d = 0; d < 3; d++) begin
                idx = e - (lat[d] - 1);
                n_checks++;
                if (out_valid_d[d] !== ((idx >= 0) && (idx < 8))) begin
                    n_fail++;
                    $display("[TB] FAIL stream_valid[S=%0d,e=%0d]: got %b expected %b", lat[d], e, out_valid_d[d], (idx >= 0) && (idx < 8));
                end
                if (idx >= 0 && idx < 8) begin
                    n_checks++;
                    if ({sum_d[d], cout_d[d], ovf_d[d]} !== ex[idx]) begin
                        n_fail++;
                        $display("[TB] FAIL stream_data[S=%0d,t=%0d]: got %h expected %h", lat[d], idx, {sum_d[d], cout_d[d], ovf_d[d]}, ex[idx]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ta [3] = '{16'h1234, 16'hF000, 16'h8000};
        logic [W-1:0] tb [3] = '{16'h4321, 16'h1000, 16'h8000};
        logic [W+1:0] ex [3];
        flush(4);
        for (int i = 0; i < 3; i++) ex[i] = model(ta[i], tb[i], 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(ta[i], tb[i], 1'b0, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (in_ready_d[0] !== 1'b0 || out_valid_d[0] !== 1'b1 || {sum_d[0], cout_d[0], ovf_d[0]} !== ex[0]) begin
                n_fail++;
                $display("[TB] FAIL stall_hold[%0d]: got rdy=%b v=%b data=%h expected 0/1/%h", i, in_ready_d[0], out_valid_d[0], {sum_d[0], cout_d[0], ovf_d[0]}, ex[0]);
            end
            if (i < 3) tick();
        end
        out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            tick(); #1;
            n_checks++;
            if (out_valid_d[0] !== 1'b1 || {sum_d[0], cout_d[0], ovf_d[0]} !== ex[i]) begin
                n_fail++;
                $display("[TB] FAIL stall_drain[%0d]: got v=%b data=%h expected 1/%h", i, out_valid_d[0], {sum_d[0], cout_d[0], ovf_d[0]}, ex[i]);
            end
        end
        tick(); #1;
        n_checks++;
        if (out_valid_d[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_no_dup: got out_valid=%b expected 0", out_valid_d[0]); end
    endtask

    task automatic test_random_traffic();
        logic [W+1:0] q [$];
        logic [W+1:0] exp_v;
        int sent = 0;
        int recv = 0;
        flush(20);
        for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
            @(negedge clk);
            if (out_valid_d[0] && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL random_extra: got result %h expected none", {sum_d[0], cout_d[0], ovf_d[0]});
                end else begin
                    exp_v = q.pop_front();
                    if ({sum_d[0], cout_d[0], ovf_d[0]} !== exp_v) begin
                        n_fail++;
                        $display("[TB] FAIL random_data[%0d]: got %h expected %h", recv, {sum_d[0], cout_d[0], ovf_d[0]}, exp_v);
                    end
                end
                recv++;
            end
            if (in_valid && in_ready_d[0]) begin
                q.push_back(model(a, b, cin, sub));
                sent++;
            end
            @(posedge clk);
            #1;
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = 1'($urandom);
            sub       = 1'($urandom);
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (recv != 1000 || q.size() != 0) begin
            n_fail++; $display("[TB] FAIL random_count: got recv=%0d pending=%0d expected 1000/0", recv, q.size());
        end
    endtask

    task automatic test_reset_midflight();
        flush(20);
        for (int i = 0; i < 4; i++) begin
            drive(16'h1111 + W'(i), 16'h2222, 1'b0, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        #2;
        n_checks++;
        if (out_valid_d[0] !== 1'b1 || sum_d[0] !== 16'h3333) begin
            n_fail++; $display("[TB] FAIL rst_pre: got v=%b sum=%h expected 1/3333", out_valid_d[0], sum_d[0]);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid_d[0] !== 1'b0 || sum_d[0] !== 16'h0000 || cout_d[0] !== 1'b0 || ovf_d[0] !== 1'b0 || in_ready_d[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rst_async: got v=%b sum=%h c=%b o=%b rdy=%b expected 0/0000/0/0/1", out_valid_d[0], sum_d[0], cout_d[0], ovf_d[0], in_ready_d[0]);
        end
        #2 reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(); #1;
            n_checks++;
            if (out_valid_d[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_stale[%0d]: got out_valid=%b expected 0", i, out_valid_d[0]); end
        end
        drive(16'h1234, 16'h1111, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick(); tick(); #1;
        n_checks++;
        if (out_valid_d[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_next_early: got out_valid=%b expected 0", out_valid_d[0]); end
        tick(); #1;
        n_checks++;
        if (out_valid_d[0] !== 1'b1 || sum_d[0] !== 16'h2345 || cout_d[0] !== 1'b0 || ovf_d[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_next: got v=%b sum=%h c=%b o=%b expected 1/2345/0/0", out_valid_d[0], sum_d[0], cout_d[0], ovf_d[0]);
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub_overflow();
        test_slice_carry();
        test_back_to_back();
        test_backpressure();
        test_random_traffic();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined adder/subtractor built from registered carry-chain slices. It accepts one operand pair per cycle under a valid/ready handshake. It returns sum, carry/borrow and signed overflow a fixed STAGES cycles later. It replaces the flat ripple adder on datapaths that are too wide to close timing in one cycle, and it is the standard arithmetic core for the ALU and accumulator blocks.

## Interface

Parameters:
- WIDTH, 16: operand and result width in bits. Must be at least 2.
- STAGES, 4: number of pipeline stages. Must be at least 1 and must divide WIDTH exactly. Slice width is SW = WIDTH/STAGES.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: operand pair is presented.
- in_ready, output, 1: block accepts the pair this cycle.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- cin, input, 1: carry-in when adding, borrow-in when subtracting.
- sub, input, 1: 0 selects A+B+cin; 1 selects A−B−cin.
- out_valid, output, 1: result is presented.
- out_ready, input, 1: downstream accepts the result.
- sum, output, WIDTH: result, modulo 2^WIDTH.
- cout, output, 1: carry-out when adding; borrow-out when subtracting (1 means A < B+cin, unsigned).
- ovf, output, 1: two's-complement signed overflow.

## Operation

- Operand conditioning at acceptance:
  - Bop = sub ? ~b : b
  - c0 = sub ? ~cin : cin
  - Internally always computes a + Bop + c0.
- Slice k (k = 0..STAGES−1) is computed in stage k:
  - Adds bits [k·SW +: SW] of A and Bop, plus the carry registered from stage k−1 (c0 for stage 0).
  - Registers its SW-bit partial sum and its carry.
  - Unprocessed upper operand slices are carried forward in skew registers.
  - Completed lower sum slices are carried forward in de-skew registers, so all slices of one transaction leave together.
- Final outputs:
  - cout = final carry XOR sub.
  - ovf = carry into MSB XOR carry out of MSB. The carry into the MSB is taken from the last stage's slice, bit SW−1.
- Each stage holds a valid bit. The output register is stage STAGES−1; out_valid is its valid bit.
- Flow control uses one global enable: adv = !out_valid || out_ready.
  - in_ready = adv (combinational; does not depend on in_valid).
  - A transaction is accepted when in_valid && in_ready.
  - When adv=1, every stage loads from its predecessor. Stage 0 loads the new operands with valid = in_valid.
  - When adv=0, every stage register, including sum/cout/ovf/out_valid, holds.
- Bubbles propagate as valid=0. A bubble ahead of a stalled output is not compressed.
- Results leave strictly in acceptance order; none are dropped or duplicated.
- Data registers of invalid stages are don't-care internally. However, sum/cout/ovf must read 0 whenever out_valid=0.

## Timing

- Reset: asserting reset immediately clears all valid bits and forces sum=0, cout=0, ovf=0 and out_valid=0. in_ready reads 1 while reset is asserted and after release.
- Reset mid-operation discards every in-flight transaction. No result accepted before reset may appear after it.
- Latency: a transaction accepted at edge n appears with out_valid=1 after edge n+STAGES−1. With STAGES=1, the result is registered on the accepting edge.
- Throughput: one transaction per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, sum/cout/ovf/out_valid are stable and in_ready=0.
- Simultaneous output acceptance and input acceptance in the same cycle is legal and loses nothing.
- Carry rules:
  - Carries cross slice boundaries only through stage registers, so there is no combinational path longer than SW bits plus one.
  - Wrap-around is modulo 2^WIDTH.

## Test plan

All scenarios use WIDTH=16 and STAGES=4 unless noted.

- Add wrap: a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 → out_valid asserts 4 cycles after acceptance with sum=0x0000, cout=1, ovf=0.
- Subtract overflow: a=0x8000, b=0x0001, cin=0, sub=1 → sum=0x7FFF, cout=0, ovf=1. Then a=0x0003, b=0x0005, cin=1, sub=1 → sum=0xFFFD, cout=1, ovf=0.
- Slice-boundary carry: a=0x0FFF, b=0x0001, cin=0 → sum=0x1000, cout=0. Then a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, ovf=1.
- Streaming: 8 back-to-back random transactions with out_ready=1 → 8 results on 8 consecutive cycles, in order, each matching a reference model. Repeat with STAGES=1 and STAGES=16.
- Backpressure: out_ready=0 for 3 cycles while results are pending → in_ready=0, outputs stable, then all results delivered once in order. Add random in_valid gaps and random out_ready toggling for 1000 transactions → zero mismatches.
- Reset mid-flight: assert reset asynchronously with 3 transactions in flight → out_valid=0 and sum=0 before the next clock edge. After release, no stale result appears, and the next accepted pair returns its result after 4 cycles.
